// File: rtl/divchk_pkg.sv
// divchk_pkg: shared state encoding and width helpers for the serial divisibility checker.
package divchk_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int DIVCHK_MIN_W = 2;
   function automatic int divchk_rw(input int divisor);
      return $clog2(divisor);
   endfunction
   function automatic int divchk_cw(input int data_w);
      return $clog2(data_w + 1);
   endfunction
endpackage

// File: rtl/divchk_mod_step.sv
// divchk_mod_step: one MSB-first remainder step, (2r + b) mod DIVISOR.
module divchk_mod_step
   import divchk_pkg::*;
#(
   parameter int DIVISOR = 3,
   localparam int RW = divchk_rw(DIVISOR)
) (
   input  logic [RW-1:0] r,
   input  logic          b,
   output logic [RW-1:0] r_next
);
   localparam logic [RW:0] D = (RW+1)'(DIVISOR);
   logic [RW:0] t;
   // r < DIVISOR keeps 2r + b below 2*DIVISOR, so one subtract is enough
   always_comb begin
      t = {r, b};
      r_next = RW'((t >= D) ? t - D : t);
   end
endmodule

// File: rtl/divisibility_checker_serial.sv
// divisibility_checker_serial: bit-serial |in_data| mod DIVISOR test on a valid/ready stream.
// Define DIVCHK_REMAINDER_OUT_EN to expose the final magnitude remainder as a port.
module divisibility_checker_serial
   import divchk_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIVISOR = 3,
   parameter int SIGNED = 1,
   localparam int RW = divchk_rw(DIVISOR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              divisible
`ifdef DIVCHK_REMAINDER_OUT_EN
   ,
   output logic [RW-1:0]     remainder
`endif
);
   localparam int CW = divchk_cw(DATA_W);
   if (DATA_W < DIVCHK_MIN_W || DIVISOR < DIVCHK_MIN_W) begin : g_bad_cfg
      $error("DATA_W and DIVISOR must both be at least 2");
   end
   state_t state, state_next;
   logic [DATA_W-1:0] shreg, mag;
   logic [RW-1:0] r, r_next;
   logic [CW-1:0] cnt;
   logic last;
   // negation of the most negative value wraps to its correct unsigned magnitude
   assign mag = (SIGNED != 0 && in_data[DATA_W-1]) ? -in_data : in_data;
   assign last = cnt == CW'(1);
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
`ifdef DIVCHK_REMAINDER_OUT_EN
   assign remainder = r;
`endif
   divchk_mod_step #(.DIVISOR(DIVISOR)) u_step (
      .r(r),
      .b(shreg[DATA_W-1]),
      .r_next(r_next)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_next;
   always_comb begin
      state_next = state;
      state_next = (state == IDLE && in_valid) ? BUSY :
                   (state == BUSY && last) ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shreg <= '0;
         r <= '0;
         cnt <= '0;
         divisible <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         shreg <= mag;
         r <= '0;
         cnt <= CW'(DATA_W);
      end else if (state == BUSY) begin
         r <= r_next;
         shreg <= shreg << 1;
         cnt <= cnt - 1'b1;
         if (last) divisible <= r_next == '0;
      end
endmodule

// File: tb/tb_divisibility_checker_serial.sv
// tb_divisibility_checker_serial: transaction-level model check plus literal vectors for three configurations.
module tb_divisibility_checker_serial;
   logic clk, rst, in_valid, out_ready;
   logic [7:0] in_data;
   logic [15:0] d16;
   logic ir0, ov0, div0, ir1, ov1, div1, ir2, ov2, div2;
`ifdef DIVCHK_REMAINDER_OUT_EN
   logic [1:0] rem0;
   logic [2:0] rem1, rem2;
`endif
   int total = 0, bad = 0, cyc = 0;

   divisibility_checker_serial #(.DATA_W(8), .DIVISOR(3), .SIGNED(1)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir0),
      .out_valid(ov0), .out_ready(out_ready), .divisible(div0)
`ifdef DIVCHK_REMAINDER_OUT_EN
      , .remainder(rem0)
`endif
   );
   divisibility_checker_serial #(.DATA_W(8), .DIVISOR(5), .SIGNED(0)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
      .out_valid(ov1), .out_ready(out_ready), .divisible(div1)
`ifdef DIVCHK_REMAINDER_OUT_EN
      , .remainder(rem1)
`endif
   );
   divisibility_checker_serial #(.DATA_W(16), .DIVISOR(7), .SIGNED(1)) dut2 (
      .clk(clk), .rst(rst), .in_data(d16), .in_valid(in_valid), .in_ready(ir2),
      .out_valid(ov2), .out_ready(out_ready), .divisible(div2)
`ifdef DIVCHK_REMAINDER_OUT_EN
      , .remainder(rem2)
`endif
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int mag8(input logic [7:0] d);
      return d[7] ? 256 - int'(d) : int'(d);
   endfunction

   // transaction model of dut0: accept, DATA_W serial steps, then hold result until taken
   bit m_idle = 1, m_busy = 0, m_done = 0;
   int done_at = 0, m_div = 0, m_rem = 0, p_div = 0, p_rem = 0;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_idle = 1; m_busy = 0; m_done = 0; m_div = 0; m_rem = 0;
         chk("rst_in_ready", ir0, 1);
         chk("rst_out_valid", ov0, 0);
         chk("rst_divisible", div0, 0);
      end else begin
         if (m_busy && cyc == done_at) begin
            m_busy = 0; m_done = 1; m_div = p_div; m_rem = p_rem;
         end
         chk("in_ready", ir0, int'(m_idle));
         chk("out_valid", ov0, int'(m_done));
         chk("divisible", div0, m_div);
`ifdef DIVCHK_REMAINDER_OUT_EN
         if (m_done) chk("remainder", rem0, m_rem);
`endif
         if (m_idle && in_valid) begin
            m_idle = 0; m_busy = 1; done_at = cyc + 9;
            p_rem = mag8(in_data) % 3;
            p_div = int'(p_rem == 0);
         end else if (m_done && out_ready) begin
            m_done = 0; m_idle = 1;
         end
      end
   end

   typedef struct packed {
      logic [7:0] a; logic [15:0] w;
      logic d0; logic [1:0] r0; logic d1; logic [2:0] r1; logic d2; logic [2:0] r2;
   } vec_t;
   vec_t tab [7];

   task automatic wait_ready();
      int n = 0;
      while (!(ir0 && ir1 && ir2) && n < 40) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 40) begin
         total++; bad++;
         $display("FAIL ready_timeout: in_ready still low after %0d cycles", n);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int l0 = 0, l1 = 0, l2 = 0;
      wait_ready();
      in_data = v.a; d16 = v.w; in_valid = 1;
      @(posedge clk); #1; in_valid = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (ov0 && l0 == 0) begin
            l0 = n; chk("vec_div0", div0, v.d0);
`ifdef DIVCHK_REMAINDER_OUT_EN
            chk("vec_rem0", rem0, v.r0);
`endif
         end
         if (ov1 && l1 == 0) begin
            l1 = n; chk("vec_div1", div1, v.d1);
`ifdef DIVCHK_REMAINDER_OUT_EN
            chk("vec_rem1", rem1, v.r1);
`endif
         end
         if (ov2 && l2 == 0) begin
            l2 = n; chk("vec_div2", div2, v.d2);
`ifdef DIVCHK_REMAINDER_OUT_EN
            chk("vec_rem2", rem2, v.r2);
`endif
         end
      end
      chk("lat0", l0, 8);
      chk("lat1", l1, 8);
      chk("lat2", l2, 16);
   endtask

   initial begin
      int n;
      tab[0] = '{8'h03, 16'h8000, 1'b1, 2'd0, 1'b0, 3'd3, 1'b0, 3'd1};
      tab[1] = '{8'hFA, 16'h0000, 1'b1, 2'd0, 1'b1, 3'd0, 1'b1, 3'd0};
      tab[2] = '{8'hFF, 16'h0007, 1'b0, 2'd1, 1'b1, 3'd0, 1'b1, 3'd0};
      tab[3] = '{8'hFC, 16'hFFF9, 1'b0, 2'd1, 1'b0, 3'd2, 1'b1, 3'd0};
      tab[4] = '{8'h80, 16'h7FFF, 1'b0, 2'd2, 1'b0, 3'd3, 1'b1, 3'd0};
      tab[5] = '{8'hFE, 16'h000A, 1'b0, 2'd2, 1'b0, 3'd4, 1'b0, 3'd3};
      tab[6] = '{8'h00, 16'hFFFF, 1'b1, 2'd0, 1'b1, 3'd0, 1'b0, 3'd1};
      rst = 1; in_valid = 0; out_ready = 1; in_data = 0; d16 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      foreach (tab[i]) run_vec(tab[i]);
      // backpressure: result must hold while out_ready is low, new words refused
      wait_ready();
      out_ready = 0; in_data = 8'h06; in_valid = 1;
      @(posedge clk); #1; in_valid = 0;
      n = 0;
      while (!ov0 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_lat", n, 8);
      in_data = 8'h01; in_valid = 1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_out_valid", ov0, 1);
         chk("bp_in_ready", ir0, 0);
         chk("bp_divisible", div0, 1);
      end
      out_ready = 1;
      @(posedge clk); #1;
      chk("bp_release_ready", ir0, 1);
      chk("bp_release_valid", ov0, 0);
      chk("bp_release_div", div0, 1);
      @(posedge clk); #1; in_valid = 0;
      repeat (20) @(posedge clk);
      #1;
      // reset while busy discards the word
      run_vec(tab[0]);
      wait_ready();
      in_data = 8'h06; in_valid = 1;
      @(posedge clk); #1; in_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      #1;
      chk("mid_rst_valid", ov0, 0);
      chk("mid_rst_ready", ir0, 1);
      chk("mid_rst_div", div0, 0);
      @(posedge clk); #1 rst = 0;
      run_vec('{8'h07, 16'h0000, 1'b0, 2'd1, 1'b0, 3'd2, 1'b1, 3'd0});
      // random traffic with occasional resets, checked by the model every cycle
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 399) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = 8'($urandom);
         d16 = 16'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
      end
      @(posedge clk); #1 rst = 0;
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/divisibility_checker_serial.md
Name: divisibility_checker_serial

Overview:
- Sequential, parametrised successor to the combinational divide-by-3 checker.
- Tests whether a DATA_W-bit word (signed or unsigned) is divisible by a compile-time DIVISOR.
- Uses a bit-serial remainder state machine, one bit per clock, MSB first.
- Sits on a valid/ready stream between a producer and a result consumer, so several checkers can share an upstream source.

Parameters:
- DATA_W, 8: input word width, in bits; must be >= 2.
- DIVISOR, 3: constant divisor; must be >= 2.
- SIGNED, 1: 1 = input is two's complement; 0 = input is unsigned.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  word to check.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  checker can accept a word.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- divisible  output  1  1 when the accepted word mod DIVISOR == 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = IDLE; shift register, remainder and counter = 0.
  - in_ready = 1; out_valid = 0; divisible = 0.
- Remainder width: RW = $clog2(DIVISOR). Counter width: $clog2(DATA_W+1).
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid && in_ready, load the shift register with the magnitude of in_data, set remainder = 0, set counter = DATA_W, then go to BUSY.
  - Magnitude when SIGNED=1 and the MSB is set: the two's-complement negation, read as unsigned DATA_W bits. The most negative value (e.g. 0x80 -> 128) is therefore handled correctly.
  - Magnitude when SIGNED=0: in_data unchanged.
- BUSY:
  - in_ready = 0.
  - Each edge: r <= (2r + shreg[MSB]) reduced mod DIVISOR, using a single conditional subtract (2r + b < 2*DIVISOR always holds). Then shift left by 1 and decrement the counter.
  - On the edge where the counter goes 1 -> 0, also register divisible = (next r == 0) and go to DONE.
  - Exactly DATA_W BUSY edges per word.
- DONE:
  - out_valid = 1; divisible is held stable; in_ready = 0.
  - On the edge where out_valid && out_ready, go to IDLE. out_valid drops in the next cycle and divisible keeps its value.
  - out_ready held low: stay in DONE indefinitely.
- Latency: out_valid is high in the cycle after the DATA_W-th edge following acceptance. Throughput is one word per DATA_W+2 cycles.
- Zero input: result is divisible = 1.
- in_valid while not in IDLE: ignored; the producer must hold the word.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values. The in-flight word is discarded and no out_valid is produced.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: DIVCHK_REMAINDER_OUT_EN.
- Defined:
  - Adds output port remainder [RW-1:0], registered alongside divisible and equal to |in_data| mod DIVISOR.
  - Reset value 0; valid while out_valid = 1.
  - Sign of the input is not applied to it (magnitude remainder).
- Undefined: port absent; the remainder register stays internal.

Decomposition:
- Package divchk_pkg:
  - State enum: IDLE, BUSY, DONE.
  - Function divchk_rw(divisor) returning $clog2(divisor).
  - Localparam helpers for the counter width.
- Sub-module divchk_mod_step: combinational single step, taking r and bit b and returning (2r + b) reduced mod DIVISOR, parametrised by DIVISOR. Instantiated once in the top module.
- Magnitude logic and the FSM stay in the top module.

Test Plan:
- Defaults, in_data=0x03, out_ready=1: out_valid rises 8 cycles after the accept edge; divisible=1; with the macro, remainder=0.
- Defaults, sequence 0xFA(-6), 0xFF(-1), 0xFC(-4), 0x80(-128): divisible = 1, 0, 0, 0; with the macro, remainders 0, 1, 1, 2.
- SIGNED=0, DIVISOR=5, DATA_W=8: 0xFF (255) -> 1; 0xFE (254) -> 0 with remainder 4; 0x00 -> 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: out_valid and divisible stay stable, in_ready=0, and a new in_valid is not accepted.
  - Release out_ready: in_ready=1 in the following cycle.
- Reset mid-operation: assert rst 3 cycles into BUSY for 0x06. Outputs return to reset values asynchronously and out_valid never pulses. Next word 0x07 -> divisible=0.
- DATA_W=16, DIVISOR=7, 0x8000 (-32768): 32768 mod 7 = 1, so divisible=0; latency is 16 cycles.
